shape_stream: RTL and testbench
===============================

# shape_stream

Parametrised, handshaked successor to the combinational shape byte generator. On a start pulse it scans a full display frame page by page and column by column. For each (page, column) position it emits one DATA_W-bit column byte of the selected shape on a valid/ready stream, which feeds the LCD write controller. A frame counter supplies an animation phase, so moving shapes need no external counter.

## Interface
- DATA_W, 8, pixels per column byte (one page row band); power of two
- COLS, 320, columns per page; X_W = $clog2(COLS)
- PAGES, 8, pages per frame; power of two; PAGE_W = max(1, $clog2(PAGES))
- SHAPE_W, 4, shape select width
- PHASE_W, 5, animation phase counter width
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to render one frame
- shape_sel  in  SHAPE_W  shape code; sampled only when start is accepted
- db  out  DATA_W  column byte; bit b is pixel row y = page*DATA_W + b
- db_valid  out  1  db, x, page, sof and eol are valid
- db_ready  in  1  consumer accepts the current byte
- x  out  X_W  column of the current byte
- page  out  PAGE_W  page of the current byte
- sof  out  1  first byte of the frame (x=0, page=0)
- eol  out  1  last column of a page (x=COLS-1)
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the last byte is accepted
- phase  out  PHASE_W  current animation phase

## Operation
- FSM states are IDLE, SCAN and DONE. Reset state is IDLE.
- IDLE: when start=1, latch shape_sel into shape_q, set x=0 and page=0, and go to SCAN.
- SCAN: db_valid=1. A transfer occurs on db_valid & db_ready.
  - On a transfer, x increments.
  - At x=COLS-1, x wraps to 0 and page increments.
  - A transfer at x=COLS-1, page=PAGES-1 goes to DONE.
- DONE: done=1 for one cycle and phase increments (wraps modulo 2^PHASE_W). The FSM then returns to IDLE.
- start is ignored outside IDLE. A change on shape_sel during a frame has no effect.
- Pixel rule uses H = PAGES*DATA_W and ph = phase. Every pixel value is 1 = on.
  - 0 blank: all 0
  - 1 fill: all 1
  - 2 hstripes: y[1] ^ ph[0]
  - 3 vstripes: x[1] ^ ph[0]
  - 4 checker: x[2] ^ y[2] ^ ph[0]
  - 5 box: x==0 | x==COLS-1 | y==0 | y==H-1
  - 6 diagonal: y == ((x + ph) & (H-1))
  - 7 crosshair: x==COLS/2 | y==H/2
  - 8..max: blank
- Arithmetic: x + ph is computed at max(X_W, PHASE_W)+1 bits before masking. There is no overflow at x=COLS-1 with ph at maximum.

## Timing
- Reset values: db=0, db_valid=0, x=0, page=0, sof=0, eol=0, busy=0, done=0, phase=0, state=IDLE.
- All outputs are registered.
- Latency: db_valid rises on the cycle after start is accepted, and the first byte is x=0, page=0 with sof=1.
- Back-pressure:
  - While db_valid=1 and db_ready=0, db, x, page, sof and eol hold stable.
  - db_valid never drops mid-frame.
  - With db_ready tied high, one byte is transferred per cycle. A frame takes COLS*PAGES cycles of db_valid, followed by one DONE cycle.
- busy is 1 from the cycle after start until the DONE cycle inclusive. done and busy are both 1 during DONE.
- start may be accepted on the cycle after DONE, i.e. in IDLE. The minimum frame-to-frame gap is 2 cycles without valid.
- rst_n asserted mid-frame aborts the frame immediately. All outputs return to reset values and phase clears; no done pulse is produced.

## Configuration
- SHAPE_STREAM_ANIM_EN defined: phase increments in DONE as above. Shapes 2, 3, 4 and 6 move between frames.
- Not defined: the phase register and its logic are removed. phase is tied to 0 and shapes are static. All other behaviour is unchanged.

## Structure
- Package shape_pkg holds:
  - the shape code constants SHAPE_BLANK..SHAPE_CROSS (values 0..7)
  - the FSM state enum (IDLE, SCAN, DONE)
  - a function clog2_min1
- Sub-module shape_pixel: purely combinational. It maps (shape, x, page, phase) to a DATA_W-bit column byte using one generate loop over bits.
- shape_stream contains the FSM, the counters and the output registers.

## Test plan
Parameters for these tests: COLS=8, PAGES=2, DATA_W=8 (H=16).
- Reset with shape 1 and db_ready=1 → 16 bytes, all 8'hFF. sof only on byte 0; eol on bytes 7 and 15. done pulses once, then phase=1.
- Shape 5 (box) → page 0 bytes: x=0 8'hFF, x=1..6 8'h01, x=7 8'hFF. Page 1: x=0 8'hFF, x=1..6 8'h80, x=7 8'hFF.
- Shape 6 with phase=0, then a second frame with phase=1 → page 0 x=0 is 8'h01 in frame 1 and 8'h02 in frame 2 (ANIM_EN defined). Frame 2 is 8'h01 when the macro is undefined.
- db_ready toggled 1,0,0,1 on each byte → outputs held while stalled, no byte lost or duplicated, 16 transfers total.
- start pulsed mid-frame with a new shape_sel → ignored; the frame completes with the original shape.
- rst_n pulled low at byte 5 → db_valid=0 and busy=0 asynchronously, no done pulse. A new start renders the full frame from x=0.

Source files
------------

// File: rtl/shape_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shape_pkg
// Description : Shared shape codes, scan FSM state type and width helper for
//               the shape_stream column-byte generator.
// Revision    : 1.0 - initial release
// ============================================================================
package shape_pkg;

   // Shape select codes; anything above SHAPE_CROSS renders blank
   localparam int SHAPE_BLANK   = 0;
   localparam int SHAPE_FILL    = 1;
   localparam int SHAPE_HSTRIPE = 2;
   localparam int SHAPE_VSTRIPE = 3;
   localparam int SHAPE_CHECKER = 4;
   localparam int SHAPE_BOX     = 5;
   localparam int SHAPE_DIAG    = 6;
   localparam int SHAPE_CROSS   = 7;

   // Frame scan states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_e;

   // Bit width for an index of 'value' entries, never narrower than one bit
   function automatic int clog2_min1(input int value);
      return (value <= 2) ? 1 : $clog2(value);
   endfunction

endpackage : shape_pkg
`default_nettype wire

// File: rtl/shape_pixel.sv
`default_nettype none
// ============================================================================
// Module      : shape_pixel
// Description : Combinational map from (shape, column, page, phase) to one
//               DATA_W-bit column byte; bit b is pixel row page*DATA_W + b.
// Revision    : 1.0 - initial release
// ============================================================================
module shape_pixel
   import shape_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int COLS    = 320,
   parameter int PAGES   = 8,
   parameter int SHAPE_W = 4,
   parameter int PHASE_W = 5,
   parameter int X_W     = $clog2(COLS),
   parameter int PAGE_W  = clog2_min1(PAGES)
) (
   input  logic [SHAPE_W-1:0] shape_i,
   input  logic [X_W-1:0]     x_i,
   input  logic [PAGE_W-1:0]  page_i,
   input  logic [PHASE_W-1:0] phase_i,
   output logic [DATA_W-1:0]  col_o
);

   localparam int H   = PAGES * DATA_W;
   localparam int Y_W = $clog2(H) + 1;
   localparam int SH  = $clog2(DATA_W);
   // Common compare width: wide enough for x+phase without overflow, for any
   // row index, and for the bit-2 taps used by the stripe/checker shapes.
   localparam int CW0 = ((X_W > PHASE_W) ? X_W : PHASE_W) + 1;
   localparam int CW1 = (CW0 > Y_W) ? CW0 : Y_W;
   localparam int CW  = (CW1 > 3) ? CW1 : 3;

   logic [CW-1:0] w_x;
   logic [CW-1:0] w_ph;
   logic [CW-1:0] w_sum;
   logic [CW-1:0] w_ybase;
   logic [31:0]   w_code;

   assign w_x     = CW'(x_i);
   assign w_ph    = CW'(phase_i);
   assign w_sum   = (w_x + w_ph) & CW'(H - 1);
   assign w_ybase = CW'(page_i) << SH;
   assign w_code  = 32'(shape_i);

   for (genvar b = 0; b < DATA_W; b++) begin : g_bit
      logic [CW-1:0] w_y;
      logic          w_pix;

      assign w_y = w_ybase | CW'(b);

      // Evaluate the selected shape rule for this pixel row
      always_comb begin
         w_pix = 1'b0;
         case (w_code)
            SHAPE_FILL:    w_pix = 1'b1;
            SHAPE_HSTRIPE: w_pix = w_y[1] ^ w_ph[0];
            SHAPE_VSTRIPE: w_pix = w_x[1] ^ w_ph[0];
            SHAPE_CHECKER: w_pix = w_x[2] ^ w_y[2] ^ w_ph[0];
            SHAPE_BOX:     w_pix = (w_x == '0) || (w_x == CW'(COLS - 1)) ||
                                   (w_y == '0) || (w_y == CW'(H - 1));
            SHAPE_DIAG:    w_pix = (w_y == w_sum);
            SHAPE_CROSS:   w_pix = (w_x == CW'(COLS / 2)) || (w_y == CW'(H / 2));
            default:       w_pix = 1'b0;
         endcase
      end

      assign col_o[b] = w_pix;
   end : g_bit

endmodule : shape_pixel
`default_nettype wire

// File: rtl/shape_stream.sv
`default_nettype none
// ============================================================================
// Module      : shape_stream
// Description : Scans one display frame per start pulse, page by page and
//               column by column, emitting one shape column byte per
//               position on a valid/ready stream. Optional animation phase
//               advances once per completed frame.
// Config      : SHAPE_STREAM_ANIM_EN - enables the frame phase counter;
//               when undefined phase is tied to 0 and shapes are static.
// Revision    : 1.0 - initial release
// ============================================================================
module shape_stream
   import shape_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int COLS    = 320,
   parameter int PAGES   = 8,
   parameter int SHAPE_W = 4,
   parameter int PHASE_W = 5,
   localparam int X_W    = $clog2(COLS),
   localparam int PAGE_W = clog2_min1(PAGES)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [SHAPE_W-1:0] shape_sel,
   output logic [DATA_W-1:0]  db,
   output logic               db_valid,
   input  logic               db_ready,
   output logic [X_W-1:0]     x,
   output logic [PAGE_W-1:0]  page,
   output logic               sof,
   output logic               eol,
   output logic               busy,
   output logic               done,
   output logic [PHASE_W-1:0] phase
);

   state_e              state_q, state_d;
   logic [X_W-1:0]      x_q, x_d;
   logic [PAGE_W-1:0]   page_q, page_d;
   logic [SHAPE_W-1:0]  shape_q, shape_d;
   logic [DATA_W-1:0]   db_q, db_d;
   logic                valid_q, valid_d;
   logic                sof_q, sof_d;
   logic                eol_q, eol_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic                w_fire;
   logic                w_last_col;
   logic                w_last_page;
   logic [DATA_W-1:0]   w_col;
   logic [PHASE_W-1:0]  w_phase;

   assign w_fire      = valid_q & db_ready;
   assign w_last_col  = (x_q == X_W'(COLS - 1));
   assign w_last_page = (page_q == PAGE_W'(PAGES - 1));

`ifdef SHAPE_STREAM_ANIM_EN
   logic [PHASE_W-1:0] phase_q;

   // Advance the animation phase once per completed frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= '0;
      end else if (state_q == DONE) begin
         phase_q <= phase_q + 1'b1;
      end
   end

   assign w_phase = phase_q;
`else
   assign w_phase = '0;
`endif

   // Pixel generator works on the next position so the byte is registered
   // together with its coordinates.
   shape_pixel #(
      .DATA_W  (DATA_W),
      .COLS    (COLS),
      .PAGES   (PAGES),
      .SHAPE_W (SHAPE_W),
      .PHASE_W (PHASE_W),
      .X_W     (X_W),
      .PAGE_W  (PAGE_W)
   ) u_pixel (
      .shape_i (shape_d),
      .x_i     (x_d),
      .page_i  (page_d),
      .phase_i (w_phase),
      .col_o   (w_col)
   );

   // Next-state: frame sequencing, scan counters and output flags
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      page_d  = page_q;
      shape_d = shape_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SCAN;
               x_d     = '0;
               page_d  = '0;
               shape_d = shape_sel;
               valid_d = 1'b1;
               busy_d  = 1'b1;
            end
         end
         SCAN: begin
            if (w_fire) begin
               if (w_last_col) begin
                  x_d = '0;
                  if (w_last_page) begin
                     state_d = DONE;
                     page_d  = '0;
                     valid_d = 1'b0;
                     done_d  = 1'b1;
                  end else begin
                     page_d = page_q + 1'b1;
                  end
               end else begin
                  x_d = x_q + 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase

      // Flags and byte follow the next position; a stalled byte is simply
      // recomputed from unchanged inputs and therefore holds.
      sof_d = valid_d && (x_d == '0) && (page_d == '0);
      eol_d = valid_d && (x_d == X_W'(COLS - 1));
      db_d  = valid_d ? w_col : '0;
   end

   // State, counters and registered outputs; reset aborts any frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         x_q     <= '0;
         page_q  <= '0;
         shape_q <= '0;
         db_q    <= '0;
         valid_q <= 1'b0;
         sof_q   <= 1'b0;
         eol_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         page_q  <= page_d;
         shape_q <= shape_d;
         db_q    <= db_d;
         valid_q <= valid_d;
         sof_q   <= sof_d;
         eol_q   <= eol_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign db       = db_q;
   assign db_valid = valid_q;
   assign x        = x_q;
   assign page     = page_q;
   assign sof      = sof_q;
   assign eol      = eol_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign phase    = w_phase;

endmodule : shape_stream
`default_nettype wire

// File: tb/tb_shape_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_shape_stream
// Description : Self-checking bench for shape_stream (COLS=8, PAGES=2,
//               DATA_W=8) with a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shape_stream;

   localparam int COLS  = 8;
   localparam int PAGES = 2;
   localparam int DW    = 8;
   localparam int H     = PAGES * DW;
   localparam int NBYTE = COLS * PAGES;
`ifdef SHAPE_STREAM_ANIM_EN
   localparam bit ANIM = 1'b1;
`else
   localparam bit ANIM = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [3:0] shape_sel;
   logic [7:0] db;
   logic       db_valid;
   logic       db_ready;
   logic [2:0] x;
   logic [0:0] page;
   logic       sof;
   logic       eol;
   logic       busy;
   logic       done;
   logic [4:0] phase;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   int         m_state = 0;   // 0 idle, 1 streaming, 2 frame complete
   int         m_idx   = 0;   // index of the byte currently offered
   int         m_shape = 0;
   int         m_phase = 0;
   logic [7:0] got[$];
   int         done_cnt = 0;

   shape_stream #(
      .DATA_W  (DW),
      .COLS    (COLS),
      .PAGES   (PAGES),
      .SHAPE_W (4),
      .PHASE_W (5)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .shape_sel (shape_sel),
      .db        (db),
      .db_valid  (db_valid),
      .db_ready  (db_ready),
      .x         (x),
      .page      (page),
      .sof       (sof),
      .eol       (eol),
      .busy      (busy),
      .done      (done),
      .phase     (phase)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Column byte straight from the pixel rules
   function automatic logic [7:0] model_byte(input int shp, input int cx, input int pg, input int ph);
      logic [7:0] r;
      int y;
      int p;
      for (int b = 0; b < DW; b++) begin
         y = pg * DW + b;
         case (shp)
            1: p = 1;
            2: p = ((y / 2) % 2) ^ (ph % 2);
            3: p = ((cx / 2) % 2) ^ (ph % 2);
            4: p = ((cx / 4) % 2) ^ ((y / 4) % 2) ^ (ph % 2);
            5: p = (cx == 0 || cx == COLS - 1 || y == 0 || y == H - 1) ? 1 : 0;
            6: p = (y == ((cx + ph) % H)) ? 1 : 0;
            7: p = (cx == COLS / 2 || y == H / 2) ? 1 : 0;
            default: p = 0;
         endcase
         r[b] = p[0];
      end
      return r;
   endfunction

   // Compare DUT against the model every cycle, then step the model
   always @(negedge clk) begin
      if (!rst_n) begin
         m_state = 0;
         m_idx   = 0;
         m_phase = 0;
         check("rst_valid", db_valid, 0);
         check("rst_busy", busy, 0);
         check("rst_done", done, 0);
         check("rst_db", db, 0);
         check("rst_x", x, 0);
         check("rst_page", page, 0);
         check("rst_sof", sof, 0);
         check("rst_eol", eol, 0);
         check("rst_phase", phase, 0);
      end else begin
         check("valid", db_valid, (m_state == 1));
         check("busy", busy, (m_state != 0));
         check("done", done, (m_state == 2));
         check("phase", phase, m_phase);
         if (m_state == 1) begin
            check("x", x, m_idx % COLS);
            check("page", page, m_idx / COLS);
            check("sof", sof, (m_idx == 0));
            check("eol", eol, ((m_idx % COLS) == COLS - 1));
            check("db", db, model_byte(m_shape, m_idx % COLS, m_idx / COLS, m_phase));
         end
         if (done) done_cnt++;
         case (m_state)
            0: if (start) begin
               m_state = 1;
               m_idx   = 0;
               m_shape = int'(shape_sel);
            end
            1: if (db_ready) begin
               got.push_back(db);
               m_idx++;
               if (m_idx == NBYTE) m_state = 2;
            end
            default: begin
               m_state = 0;
               m_phase = ANIM ? (m_phase + 1) % 32 : 0;
            end
         endcase
      end
   end

   task automatic apply_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("async_valid", db_valid, 0);
      check("async_busy", busy, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // rmode: 0 always ready, 1 ready pattern 1,0,0,1, 2 random
   // inject: cycle at which a spurious start with another shape is pulsed
   task automatic do_frame(input int shp, input int rmode, input int inject);
      bit fin;
      got.delete();
      done_cnt = 0;
      @(posedge clk); #1;
      start     = 1'b1;
      shape_sel = 4'(shp);
      db_ready  = 1'b1;
      fin       = 1'b0;
      for (int c = 0; c < 400 && !fin; c++) begin
         @(posedge clk); #1;
         start     = (c == inject);
         shape_sel = (c == inject) ? 4'd0 : 4'($urandom_range(0, 15));
         case (rmode)
            0:       db_ready = 1'b1;
            1:       db_ready = ((c % 4) == 0) || ((c % 4) == 3);
            default: db_ready = 1'($urandom_range(0, 1));
         endcase
         if (done === 1'b1) fin = 1'b1;
      end
      if (!fin) check("frame_timeout", 0, 1);
      start = 1'b0;
      @(posedge clk); #1;
      check("frame_bytes", got.size(), NBYTE);
      check("done_pulses", done_cnt, 1);
   endtask

   initial begin
      int n;
      rst_n     = 1'b0;
      start     = 1'b0;
      shape_sel = 4'd0;
      db_ready  = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Fill frame: every byte all ones, phase advances once
      do_frame(1, 0, -1);
      for (int i = 0; i < got.size(); i++) check("fill_byte", got[i], 8'hFF);
      check("fill_phase", phase, ANIM ? 1 : 0);

      // Box outline
      do_frame(5, 0, -1);
      for (int i = 0; i < got.size(); i++) begin
         if (i % COLS == 0 || i % COLS == COLS - 1) check("box_edge", got[i], 8'hFF);
         else if (i < COLS)                         check("box_top", got[i], 8'h01);
         else                                       check("box_bot", got[i], 8'h80);
      end

      // Diagonal moves by one row between frames when animated
      apply_reset();
      do_frame(6, 0, -1);
      check("diag_f1", got[0], 8'h01);
      do_frame(6, 0, -1);
      check("diag_f2", got[0], ANIM ? 8'h02 : 8'h01);

      // Back-pressure pattern
      do_frame(4, 1, -1);

      // Spurious start mid-frame is ignored
      do_frame(1, 0, 5);
      for (int i = 0; i < got.size(); i++) check("ignore_start", got[i], 8'hFF);

      // Reset mid-frame aborts without a done pulse
      got.delete();
      done_cnt = 0;
      @(posedge clk); #1;
      start     = 1'b1;
      shape_sel = 4'd1;
      db_ready  = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (got.size() < 5 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("abort_reached", got.size(), 5);
      apply_reset();
      check("abort_no_done", done_cnt, 0);
      do_frame(1, 0, -1);
      check("restart_first", got[0], 8'hFF);

      // Randomized frames
      for (int f = 0; f < 10; f++) begin
         do_frame($urandom_range(0, 15), $urandom_range(0, 2), -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog actual=timeout expected=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_shape_stream
`default_nettype wire
